// File: rtl/sound_arbiter_if.sv
// Bundle between the requesters, the arbiter and the tone player.
// The master side drives requests, notes, counts and the player's done pulse;
// the slave side (the arbiter) drives grant, acknowledgements and the note stream.
interface sound_arbiter_if #(
  parameter int NOTE_W = 5
);
  logic [3:0]          req;
  logic [4*NOTE_W-1:0] note_in;
  logic [15:0]         cnt_in;
  logic                music_done;
  logic [3:0]          grant;
  logic [3:0]          note_ack;
  logic [3:0]          done;
  logic [NOTE_W-1:0]   music_data;
  logic                busy;

  modport master (
    output req, note_in, cnt_in, music_done,
    input  grant, note_ack, done, music_data, busy
  );

  modport slave (
    input  req, note_in, cnt_in, music_done,
    output grant, note_ack, done, music_data, busy
  );
endinterface

// File: rtl/sound_arbiter.sv
// Fixed-priority arbiter sharing one tone player among four requesters.
// A winner plays its whole note sequence one note at a time; after every grant
// ends (completion, abort or preemption) a silent gap is inserted before the
// next arbitration. Requester 0 has the highest priority.
module sound_arbiter #(
  parameter int GAP_CYCLES = 1000,
  parameter int NOTE_W     = 5
) (
  input logic            clk,
  input logic            rst,
  sound_arbiter_if.slave bus
);

  // Gap counter only needs to reach GAP_CYCLES-1; a zero gap still spends one
  // cycle in GAP, so the terminal count collapses to 0 in that case.
  localparam int GAP_W      = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        grant_q, grant_d;
  logic [1:0]        owner_q, owner_d;
  logic [3:0]        note_ack_q, note_ack_d;
  logic [3:0]        done_q, done_d;
  logic [NOTE_W-1:0] music_data_q, music_data_d;
  logic [3:0]        remaining_q, remaining_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic [1:0]        pick_idx;
  logic              pick_any;
  logic [3:0]        pick_cnt;
  logic [NOTE_W-1:0] owner_note;
  logic              owner_req;
  logic              lower_req;

  // Lowest-index active request wins; also fetch the winner's count and the
  // current owner's note so the FSM only deals with scalar values.
  always_comb begin
    pick_idx   = 2'd0;
    pick_any   = 1'b0;
    pick_cnt   = 4'd0;
    owner_note = '0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[k]) begin
        pick_idx = 2'(k);
        pick_any = 1'b1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (pick_idx == 2'(k)) begin
        pick_cnt = bus.cnt_in[k*4 +: 4];
      end
      if (owner_q == 2'(k)) begin
        owner_note = bus.note_in[k*NOTE_W +: NOTE_W];
      end
    end
  end

  // The owner still wants the player, and whether anyone of higher priority
  // (lower index) is now asking; grant is one-hot so grant-1 masks lower bits.
  assign owner_req = bus.req[owner_q];
  assign lower_req = |(bus.req & (grant_q - 4'd1));

  // State and registered outputs; reset silently drops any sequence in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      note_ack_q   <= '0;
      done_q       <= '0;
      music_data_q <= '0;
      remaining_q  <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      note_ack_q   <= note_ack_d;
      done_q       <= done_d;
      music_data_q <= music_data_d;
      remaining_q  <= remaining_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    note_ack_d   = '0;
    done_d       = '0;
    music_data_d = music_data_q;
    remaining_d  = remaining_q;
    gap_cnt_d    = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        grant_d      = '0;
        music_data_d = '0;
        gap_cnt_d    = '0;
        if (pick_any) begin
          owner_d     = pick_idx;
          grant_d     = 4'b0001 << pick_idx;
          remaining_d = (pick_cnt == 4'd0) ? 4'd1 : pick_cnt;
          state_d     = S_LOAD;
        end
      end

      S_LOAD: begin
        music_data_d = owner_note;
        note_ack_d   = grant_q;
        remaining_d  = remaining_q - 4'd1;
        state_d      = S_PLAY;
      end

      S_PLAY: begin
        if (bus.music_done) begin
          if (remaining_q == 4'd0) begin
            done_d       = grant_q;
            grant_d      = '0;
            music_data_d = '0;
            gap_cnt_d    = '0;
            state_d      = S_GAP;
          end else if (!owner_req || lower_req) begin
            grant_d      = '0;
            music_data_d = '0;
            gap_cnt_d    = '0;
            state_d      = S_GAP;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.grant      = grant_q;
  assign bus.note_ack   = note_ack_q;
  assign bus.done       = done_q;
  assign bus.music_data = music_data_q;
  assign bus.busy       = (state_q != S_IDLE);

  grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  ack_done_excl : assert property (@(posedge clk) disable iff (rst) !((|note_ack_q) && (|done_q)));

endmodule

// File: tb/tb_sound_arbiter.sv
// Randomised scoreboard bench for sound_arbiter.
// The driver plays requester sessions and, from the arbitration rules, pushes
// every output event it expects (with its cycle) into a queue; the monitor
// compares whatever the DUT shows against the head of that queue.
module tb_sound_arbiter;
  localparam int NW  = 5;
  localparam int NIW = 4 * NW;
  localparam int GAP = 5;
  localparam int G   = (GAP == 0) ? 1 : GAP;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sound_arbiter_if #(.NOTE_W(NW)) bus ();

  sound_arbiter #(.GAP_CYCLES(GAP), .NOTE_W(NW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [3:0]    grant;
    logic [3:0]    ack;
    logic [3:0]    done;
    logic [NW-1:0] md;
    logic          busy;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  next_arb = 0;
  logic mon_en  = 1'b0;

  logic [3:0]    prev_grant = '0;
  logic [NW-1:0] prev_md    = '0;
  logic          prev_busy  = 1'b0;

  // count rising edges so events can be stamped with the edge that makes them
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any visible change or pulse must match the expected event due now.
  always @(negedge clk) begin : monitor
    logic trig;
    logic has;
    ev_t  e;
    trig = (bus.grant != prev_grant) || (bus.busy != prev_busy) ||
           (bus.music_data != prev_md) || (bus.note_ack != 4'd0) || (bus.done != 4'd0);
    if (mon_en) begin
      has = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (has) begin
        e = exp_q.pop_front();
        checks++;
        if (!trig || bus.grant !== e.grant || bus.note_ack !== e.ack || bus.done !== e.done ||
            bus.music_data !== e.md || bus.busy !== e.busy) begin
          failures++;
          $display("[TB] FAIL event@%0d: got grant=%b ack=%b done=%b md=%0d busy=%b changed=%b, required grant=%b ack=%b done=%b md=%0d busy=%b",
                   cyc, bus.grant, bus.note_ack, bus.done, bus.music_data, bus.busy, trig,
                   e.grant, e.ack, e.done, e.md, e.busy);
        end
      end else if (trig) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected@%0d: got grant=%b ack=%b done=%b md=%0d busy=%b, required no change",
                 cyc, bus.grant, bus.note_ack, bus.done, bus.music_data, bus.busy);
      end
    end
    prev_grant = bus.grant;
    prev_md    = bus.music_data;
    prev_busy  = bus.busy;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic push(input int c, input logic [3:0] g, input logic [3:0] a,
                      input logic [3:0] d, input logic [NW-1:0] m, input logic b);
    ev_t e;
    e.cyc   = c;
    e.grant = g;
    e.ack   = a;
    e.done  = d;
    e.md    = m;
    e.busy  = b;
    exp_q.push_back(e);
  endtask

  function automatic int lowest(input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[k]) return k;
    end
    return 0;
  endfunction

  // One arbitration session. Called at a negedge; returns at a negedge.
  // abort_note / preempt_note / reset_note name the note (1-based) at whose
  // end the owner drops its request, requester 0 raises its request, or reset
  // is pulsed instead of music_done; -1 disables each.
  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] cnts,
                               input int abort_note, input int preempt_note,
                               input int reset_note, input int extra_idle, input bit noisy);
    int            target;
    int            w;
    int            n;
    int            e_cyc;
    logic [3:0]    one;
    logic [3:0]    cur_req;
    logic [NW-1:0] note;
    bit            higher_waiting;

    // gap cycles: requests ignored; idle cycles: nothing requested
    target = next_arb + extra_idle;
    while (cyc + 1 < target) begin
      bus.req        = (noisy && (cyc + 1 < next_arb)) ? 4'($urandom) : 4'b0000;
      bus.cnt_in     = 16'($urandom);
      bus.music_done = 1'($urandom);
      @(negedge clk);
    end

    // arbitration edge
    bus.req        = r;
    bus.cnt_in     = cnts;
    bus.note_in    = NIW'($urandom);
    bus.music_done = 1'($urandom);
    w   = lowest(r);
    one = 4'(1 << w);
    n   = int'(cnts[w*4 +: 4]);
    if (n == 0) n = 1;
    note = bus.note_in[w*NW +: NW];
    push(cyc + 1, one, 4'd0, 4'd0, '0, 1'b1);
    push(cyc + 2, one, one, 4'd0, note, 1'b1);
    cur_req = r;
    @(negedge clk);

    for (int k = 1; k <= n; k++) begin
      bus.music_done = 1'($urandom);
      @(negedge clk);
      bus.music_done = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);

      if (k == reset_note) begin
        rst = 1'b1;
        push(cyc + 1, 4'd0, 4'd0, 4'd0, '0, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        bus.req  = 4'b0000;
        next_arb = cyc + 1;
        return;
      end

      if (k == abort_note) cur_req[w] = 1'b0;
      if (k == preempt_note && w > 0) cur_req[0] = 1'b1;
      if (noisy && w < 3 && $urandom_range(0, 3) == 0) cur_req[$urandom_range(w + 1, 3)] = 1'b1;
      bus.req = cur_req;
      if (noisy) bus.cnt_in = 16'($urandom);
      note = NW'($urandom);
      bus.note_in[w*NW +: NW] = note;
      bus.music_done = 1'b1;
      e_cyc = cyc + 1;

      higher_waiting = 1'b0;
      for (int j = 0; j < w; j++) begin
        if (cur_req[j]) higher_waiting = 1'b1;
      end

      if (k == n) begin
        push(e_cyc, 4'd0, 4'd0, one, '0, 1'b1);
        push(e_cyc + G, 4'd0, 4'd0, 4'd0, '0, 1'b0);
        next_arb = e_cyc + G + 1;
      end else if (!cur_req[w] || higher_waiting) begin
        push(e_cyc, 4'd0, 4'd0, 4'd0, '0, 1'b1);
        push(e_cyc + G, 4'd0, 4'd0, 4'd0, '0, 1'b0);
        next_arb = e_cyc + G + 1;
      end else begin
        push(e_cyc + 1, one, one, 4'd0, note, 1'b1);
      end

      @(negedge clk);
      bus.music_done = 1'b0;
      if (next_arb == e_cyc + G + 1) return;
    end
  endtask

  // Stimulus: reset checks, scenario sessions, then random sessions.
  initial begin
    bus.req        = 4'b0000;
    bus.note_in    = '0;
    bus.cnt_in     = '0;
    bus.music_done = 1'b0;
    rst            = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_grant", int'(bus.grant), 0);
    checkOutput("reset_note_ack", int'(bus.note_ack), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_music_data", int'(bus.music_data), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    rst      = 1'b0;
    next_arb = cyc + 1;
    mon_en   = 1'b1;

    // three notes from requester 2, then the gap
    applyStimulus(4'b0100, 16'h0300, -1, -1, -1, 0, 1'b0);
    // 1 beats 3; 3 is served after 1 and the gap
    applyStimulus(4'b1010, 16'h0020, -1, -1, -1, 0, 1'b0);
    applyStimulus(4'b1000, 16'h1000, -1, -1, -1, 0, 1'b0);
    // requester 3 preempted by 0 during note 1 of 4
    applyStimulus(4'b1000, 16'h4000, -1, 1, -1, 0, 1'b0);
    applyStimulus(4'b1001, 16'h0002, -1, -1, -1, 0, 1'b0);
    // requester 1 aborts during note 2 of 5
    applyStimulus(4'b0010, 16'h0050, 2, -1, -1, 1, 1'b0);
    // count of zero plays exactly one note
    applyStimulus(4'b0001, 16'h0000, -1, -1, -1, 0, 1'b0);
    // completion outranks a simultaneous abort
    applyStimulus(4'b0010, 16'h0020, 2, -1, -1, 0, 1'b0);
    // reset while playing, then music_done noise in idle
    applyStimulus(4'b0100, 16'h0300, -1, -1, 2, 0, 1'b0);
    applyStimulus(4'b0001, 16'h0001, -1, -1, -1, 4, 1'b0);
    // reset while playing with a request granted right after release
    applyStimulus(4'b1000, 16'h3000, -1, -1, 1, 0, 1'b0);
    applyStimulus(4'b1000, 16'h2000, -1, -1, -1, 0, 1'b0);

    repeat (40) begin
      int ab;
      int pr;
      int rs;
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : -1;
      pr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : -1;
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : -1;
      applyStimulus(4'($urandom_range(1, 15)), 16'($urandom), ab, pr, rs,
                    int'($urandom_range(0, 2)), 1'b1);
    end

    bus.req        = 4'b0000;
    bus.music_done = 1'b0;
    repeat (G + 4) @(negedge clk);
    checkOutput("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound the run in case the driver or DUT wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of run by cycle %0d, required end well before", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 1000: silent cycles inserted after every grant ends; 0 means no gap.
REQ-002 Parameter NOTE_W, default 5: width of the note code passed to the tone player.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  4  level request per requester; bit 0 highest priority, bit 3 lowest.
REQ-006 note_in  input  4*NOTE_W  current note code of each requester; slice i belongs to requester i.
REQ-007 cnt_in  input  16  4-bit note count per requester (slice i = bits 4i+3:4i), sampled at grant.
REQ-008 music_done  input  1  one-cycle pulse from the tone player when the current note has finished.
REQ-009 grant  output  4  one-hot (or zero) owner of the tone player.
REQ-010 note_ack  output  4  one-cycle pulse to requester i when its note has been loaded; the requester may then present its next note.
REQ-011 done  output  4  one-cycle pulse to requester i when its full note sequence has completed.
REQ-012 music_data  output  NOTE_W  note code driven to the tone player; 0 = rest/silence.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States: IDLE, LOAD, PLAY, GAP.
REQ-015 IDLE, any req bit high: select the lowest-index set bit i, set grant to one-hot i, latch remaining = cnt_in slice i, and go to LOAD on the next edge; a cnt_in value of 0 is latched as 1.
REQ-016 IDLE, req = 0: grant = 0, music_data = 0, and the state holds.
REQ-017 LOAD lasts exactly one cycle: music_data <= note_in slice i, note_ack[i] pulses, remaining decrements by 1, then go to PLAY.
REQ-018 PLAY: music_data holds until music_done; with no music_done, all outputs hold.
REQ-019 PLAY with music_done and remaining = 0: done[i] pulses for one cycle, grant <= 0, music_data <= 0, go to GAP.
REQ-020 PLAY with music_done and req[i] low (abort): grant <= 0, music_data <= 0, no done pulse, go to GAP.
REQ-021 PLAY with music_done and any req bit of lower index than i high (preemption): grant <= 0, music_data <= 0, no done pulse, go to GAP.
REQ-022 PLAY with music_done, remaining > 0, no abort and no preemption: go to LOAD, keeping the same grant.
REQ-023 Priority when several PLAY exit conditions hold at once: completion, then abort, then preemption.
REQ-024 A preempting requester is never granted directly from PLAY; it wins arbitration in IDLE after the gap.
REQ-025 GAP: a cycle counter runs from 0 to GAP_CYCLES-1, then the state goes to IDLE; with GAP_CYCLES = 0, GAP lasts one cycle.
REQ-026 music_done is ignored in IDLE, LOAD and GAP.
REQ-027 req changes outside PLAY do not alter the current grant, except that arbitration is re-evaluated in IDLE.
REQ-028 grant has at most one bit set in every cycle.
REQ-029 note_ack and done are never high in the same cycle.
REQ-030 The remaining counter is 4 bits; it never underflows because the zero check precedes the decrement.

Reset
REQ-031 While rst is high on a clock edge: state <= IDLE; grant, note_ack, done, music_data and busy <= 0; remaining and the gap counter <= 0.
REQ-032 Reset asserted mid-sequence aborts the sequence silently: no done pulse.
REQ-033 The cycle after rst deasserts behaves as IDLE, so a pending req is granted on the first edge after reset release.

Verification
REQ-034 req = 4'b0100, cnt_in slice 2 = 3, music_done pulsed 3 times -> note_ack[2] pulses 3 times; done[2] pulses once, the cycle after the 3rd music_done; then busy holds for GAP_CYCLES cycles.
REQ-035 req = 4'b1010 together in IDLE -> grant = 4'b0010; requester 3 is granted only after requester 1 completes and the gap has elapsed.
REQ-036 Requester 3 playing note 1 of 4, then req[0] raised -> on the next music_done, grant = 0 with no done[3]; after the gap, grant = 4'b0001.
REQ-037 Requester 1 with cnt = 5 drops req[1] during note 2 -> at that note's music_done, grant = 0, music_data = 0, no done[1].
REQ-038 cnt_in slice 0 = 0 -> exactly one note is played and done[0] pulses.
REQ-039 rst high during PLAY -> next cycle all outputs are 0 and state is IDLE; music_done pulses while IDLE produce no output change.
